// File: rtl/vx_issue_warp_arbiter_if.sv
// vx_issue_warp_arbiter_if: handshake bundle between warp requesters, the issue arbiter and the operands stage
//   req_valid/req_data/req_ready : per-warp request side (slice i of req_data at [i*DATA_WIDTH +: DATA_WIDTH])
//   out_valid/out_data/out_index/out_ready : registered winner toward the operands stage
//   warp_issued : pulse on every accepted request
//   modport master = arbiter side, modport slave = requester/downstream side
interface vx_issue_warp_arbiter_if #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_W      = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1
);
  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQS-1:0]            req_ready;
  logic                           out_valid;
  logic [DATA_WIDTH-1:0]          out_data;
  logic [IDX_W-1:0]               out_index;
  logic                           out_ready;
  logic                           warp_issued;
  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_index, warp_issued
  );
  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_index, warp_issued
  );
endinterface

// File: rtl/vx_issue_warp_arbiter.sv
// vx_issue_warp_arbiter: per-issue-slice warp selector, round-robin with starvation-forced priority, one-entry elastic output
//   clk, reset (sync, active-low) ; bus : vx_issue_warp_arbiter_if.master
//   optional VX_ISSUE_ARB_PERF_EN adds perf_stalls[43:0], saturating count of requested-but-blocked cycles
module vx_issue_warp_arbiter #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_WAIT   = 15
) (
  input logic clk,
  input logic reset,
  vx_issue_warp_arbiter_if.master bus
`ifdef VX_ISSUE_ARB_PERF_EN
  ,
  output logic [43:0] perf_stalls
`endif
);
  localparam int IDX_W = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [IDX_W-1:0]      r_rr_ptr, r_out_index, w_starve_idx, w_rr_idx, w_grant, w_next_ptr;
  logic [CNT_W-1:0]      r_wait [NUM_REQS];
  logic                  r_out_valid, w_pipe_ready, w_starve, w_any, w_xfer;
  logic [DATA_WIDTH-1:0] r_out_data, w_data;
  logic [NUM_REQS-1:0]   w_ready;
  logic [2*NUM_REQS-1:0] w_rot;
  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v >= NUM_REQS ? v - NUM_REQS : v);
  endfunction
  always_comb begin
    w_any        = |bus.req_valid;
    w_pipe_ready = !r_out_valid || bus.out_ready;
    w_starve     = 1'b0;
    w_starve_idx = '0;
    w_rr_idx     = r_rr_ptr;
    // descending scans so the lowest index / nearest-to-pointer hit wins
    for (int i = NUM_REQS - 1; i >= 0; i--)
      if (bus.req_valid[i] && r_wait[i] == CNT_W'(MAX_WAIT)) begin
        w_starve     = 1'b1;
        w_starve_idx = IDX_W'(i);
      end
    // rotate valids so bit k is the requester k steps past the pointer
    w_rot = {bus.req_valid, bus.req_valid} >> r_rr_ptr;
    for (int k = NUM_REQS - 1; k >= 0; k--)
      if (w_rot[k]) w_rr_idx = wrap(int'(r_rr_ptr) + k);
    w_grant    = w_starve ? w_starve_idx : w_rr_idx;
    w_ready    = (reset && w_any && w_pipe_ready) ? NUM_REQS'(1) << w_grant : '0;
    w_xfer     = |(bus.req_valid & w_ready);
    w_next_ptr = (int'(w_grant) == NUM_REQS - 1) ? '0 : w_grant + 1'b1;
    w_data     = '0;
    for (int i = 0; i < NUM_REQS; i++)
      if (w_grant == IDX_W'(i)) w_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_rr_ptr    <= '0;
      for (int i = 0; i < NUM_REQS; i++) r_wait[i] <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_index <= w_grant;
        r_rr_ptr    <= w_next_ptr;
      end else if (bus.out_ready) r_out_valid <= 1'b0;
      // a granted valid requester always transfers, so w_ready[i] doubles as "transferred"
      for (int i = 0; i < NUM_REQS; i++)
        r_wait[i] <= (!bus.req_valid[i] || w_ready[i]) ? '0 :
                     (w_pipe_ready && r_wait[i] != CNT_W'(MAX_WAIT)) ? r_wait[i] + 1'b1 : r_wait[i];
    end
  end
  assign bus.req_ready   = w_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_index   = r_out_index;
  assign bus.warp_issued = w_xfer;
`ifdef VX_ISSUE_ARB_PERF_EN
  logic [43:0] r_perf;
  always_ff @(posedge clk) begin
    if (!reset) r_perf <= '0;
    else if (w_any && !w_pipe_ready && !(&r_perf)) r_perf <= r_perf + 1'b1;
  end
  assign perf_stalls = r_perf;
`endif
endmodule

// File: tb/tb_vx_issue_warp_arbiter.sv
// tb_vx_issue_warp_arbiter: randomized and directed check of the issue warp arbiter against a behavioural model
module tb_vx_issue_warp_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MW = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  vx_issue_warp_arbiter_if #(.NUM_REQS(N), .DATA_WIDTH(DW)) bus ();
`ifdef VX_ISSUE_ARB_PERF_EN
  logic [43:0] perf_stalls;
`endif
  vx_issue_warp_arbiter #(.NUM_REQS(N), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef VX_ISSUE_ARB_PERF_EN
    ,
    .perf_stalls(perf_stalls)
`endif
  );
  always #5 clk = ~clk;
  logic [DW-1:0] cur_data [N];
  logic [N-1:0]  cur_v = '0;
  logic [N-1:0]  last_acc = '0;
  int            m_ptr = 0;
  int            m_wait [N];
  bit            m_ov = 0;
  logic [DW-1:0] m_od = '0;
  int            m_oi = 0;
  longint        m_perf = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic step(input logic [N-1:0] v, input logic ordy, input logic rstn);
    logic [N*DW-1:0] d;
    logic [N-1:0]    exp_ready;
    bit              pr;
    int              g;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = cur_data[i];
    reset = rstn;
    bus.out_ready = ordy;
    bus.req_valid = v;
    bus.req_data = d;
    #1;
    pr = !m_ov || ordy;
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && v[i] && m_wait[i] == MW) g = i;
    for (int k = 0; k < N; k++)
      if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_ready = (rstn && g >= 0 && pr) ? N'(1) << g : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("warp_issued", 64'(bus.warp_issued), 64'(exp_ready != 0));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("out_data", 64'(bus.out_data), 64'(m_od));
    chk("out_index", 64'(bus.out_index), 64'(m_oi));
`ifdef VX_ISSUE_ARB_PERF_EN
    chk("perf_stalls", 64'(perf_stalls), 64'(m_perf));
`endif
    if (!rstn) begin
      m_ptr = 0; m_ov = 0; m_od = '0; m_oi = 0; m_perf = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      if (v != 0 && !pr && m_perf < 64'hFFF_FFFF_FFFF) m_perf++;
      if (exp_ready != 0) begin
        m_ov = 1; m_od = cur_data[g]; m_oi = g; m_ptr = (g + 1) % N;
      end else if (ordy) m_ov = 0;
      for (int i = 0; i < N; i++)
        if (!v[i] || exp_ready[i]) m_wait[i] = 0;
        else if (pr && m_wait[i] < MW) m_wait[i]++;
    end
    for (int i = 0; i < N; i++)
      if (!v[i] || exp_ready[i]) cur_data[i] = DW'($urandom);
    cur_v = v;
    last_acc = exp_ready;
  endtask
  initial begin
    logic [N-1:0] nv;
    for (int i = 0; i < N; i++) begin
      cur_data[i] = DW'($urandom);
      m_wait[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk("rst_ready", 64'(bus.req_ready), 64'h0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    end
    chk("rst_out_data", 64'(bus.out_data), 64'h0);
    step(4'b1111, 1'b1, 1'b1);
    chk("first_grant", 64'(bus.req_ready), 64'h1);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, 1'b1);
      chk("rr_index", 64'(bus.out_index), 64'(k % 4));
      chk("rr_issued", 64'(bus.warp_issued), 64'h1);
    end
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b0, 1'b1);
      chk("bp_index", 64'(bus.out_index), 64'h2);
      chk("bp_valid", 64'(bus.out_valid), 64'h1);
      chk("bp_ready", 64'(bus.req_ready), 64'h0);
    end
    step(4'b1111, 1'b1, 1'b1);
    chk("bp_release_grant", 64'(bus.req_ready), 64'h8);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b1);
    step(4'b1001, 1'b1, 1'b1);
    chk("sparse_grant_a", 64'(bus.req_ready), 64'h8);
    step(4'b1001, 1'b1, 1'b1);
    chk("sparse_grant_b", 64'(bus.req_ready), 64'h1);
    step(4'b1001, 1'b1, 1'b1);
    chk("sparse_grant_c", 64'(bus.req_ready), 64'h8);
`ifdef VX_ISSUE_ARB_PERF_EN
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    for (int k = 0; k < 11; k++) step(4'b0001, 1'b0, 1'b1);
    chk("perf_ten", 64'(perf_stalls), 64'd10);
`endif
    step(4'b0000, 1'b1, 1'b1);
    chk("idle_issued", 64'(bus.warp_issued), 64'h0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        nv[i] = (cur_v[i] && !last_acc[i]) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 6);
      step(nv, $urandom_range(0, 9) < 7, $urandom_range(0, 199) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
